pwm_dcd: RTL and testbench

PWM_DCD -- requirements
Module: pwm_dcd

---
 rtl/pwm_pkg.sv | 30 +++
 rtl/pwm_in_synch.sv | 29 ++
 rtl/pwm_dcd.sv | 91 +++++++++
 tb/tb_pwm_dcd.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty-cycle decoder.
package pwm_pkg;

    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] SPD_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] SPD_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    // Saturating up-counter step.
    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
    endfunction

    // a - b computed one bit wider, clamped to the signed CNT_W range.
    function automatic logic [CNT_W-1:0] sat_diff(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic signed [CNT_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        if (d > $signed({SPD_MAX[CNT_W-1], SPD_MAX}))
            return SPD_MAX;
        else if (d < $signed({SPD_MIN[CNT_W-1], SPD_MIN}))
            return SPD_MIN;
        else
            return d[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_in_synch.sv
// Two-flop synchronizer for an asynchronous PWM pin plus rising-edge detect.
module pwm_in_synch (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;

endmodule

// File: rtl/pwm_dcd.sv
// Recovers signed speed from an H-bridge PWM pair: hi-time(PWM1) - hi-time(PWM2)
// per PWM1 period, with stall timeout and sticky shoot-through detection.
module pwm_dcd
    import pwm_pkg::*;
#(
    parameter int TMO_CLKS = 4095
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PWM1,
    input  logic             PWM2,
    input  logic             clr_flt,
    output logic [CNT_W-1:0] spd,
    output logic             spd_vld,
    output logic             stall,
    output logic             shoot_thru
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TMO_CLKS);

    logic             p1, p2, rise1;
    state_t           state;
    logic [CNT_W-1:0] hi1_cnt, hi2_cnt, per_cnt;

    pwm_in_synch u_sync1 (.clk(clk), .rst_n(rst_n), .din(PWM1), .q(p1), .rise(rise1));
    pwm_in_synch u_sync2 (.clk(clk), .rst_n(rst_n), .din(PWM2), .q(p2), .rise());

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hi1_cnt    <= '0;
            hi2_cnt    <= '0;
            per_cnt    <= '0;
            spd        <= '0;
            spd_vld    <= 1'b0;
            stall      <= 1'b1;
            shoot_thru <= 1'b0;
        end else begin
            spd_vld <= 1'b0;

            // Set has priority over a simultaneous clear.
            if (p1 && p2)
                shoot_thru <= 1'b1;
            else if (clr_flt)
                shoot_thru <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (rise1) begin
                        // Boundary cycle is cycle 1 of the new period.
                        state   <= MEAS;
                        hi1_cnt <= CNT_W'(1);
                        hi2_cnt <= {{(CNT_W-1){1'b0}}, p2};
                        per_cnt <= CNT_W'(1);
                    end else begin
                        per_cnt <= inc_sat(per_cnt, 1'b1);
                        if (per_cnt == TMO) begin
                            spd     <= '0;
                            spd_vld <= ~stall;
                            stall   <= 1'b1;
                        end
                    end
                end
                MEAS: begin
                    if (rise1) begin
                        spd     <= sat_diff(hi1_cnt, hi2_cnt);
                        spd_vld <= 1'b1;
                        stall   <= 1'b0;
                        hi1_cnt <= CNT_W'(1);
                        hi2_cnt <= {{(CNT_W-1){1'b0}}, p2};
                        per_cnt <= CNT_W'(1);
                    end else if (per_cnt == TMO) begin
                        spd     <= '0;
                        spd_vld <= 1'b1;
                        stall   <= 1'b1;
                        state   <= IDLE;
                        hi1_cnt <= '0;
                        hi2_cnt <= '0;
                        per_cnt <= '0;
                    end else begin
                        hi1_cnt <= inc_sat(hi1_cnt, p1);
                        hi2_cnt <= inc_sat(hi2_cnt, p2);
                        per_cnt <= inc_sat(per_cnt, 1'b1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_dcd.sv
// Directed bench for pwm_dcd: stimulus pushes expected spd_vld events, a monitor pops and checks them.
module tb_pwm_dcd;

    localparam int TMO = 4095;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PWM1, PWM2, clr_flt;
    logic [11:0] spd;
    logic        spd_vld, stall, shoot_thru;

    typedef struct {
        logic [11:0] spd;
        logic        stall;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   last_rise = 0;
    int   n_chk = 0;
    int   n_err = 0;

    pwm_dcd #(.TMO_CLKS(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .PWM1(PWM1), .PWM2(PWM2), .clr_flt(clr_flt),
        .spd(spd), .spd_vld(spd_vld), .stall(stall), .shoot_thru(shoot_thru)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every spd_vld pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && spd_vld) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_vld: got spd 0x%0h at cycle %0d, expected no pulse", spd, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("spd", int'(spd), int'(e.spd));
                chk("stall_at_vld", int'(stall), int'(e.stall));
                chk("vld_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic hold(input logic a, input logic b, input int n);
        PWM1 = a;
        PWM2 = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // PWM1 rising edge; optionally expect the measurement of the period it closes.
    task automatic rise(input bit exp_v, input int exp_spd);
        exp_t e;
        if (exp_v) begin
            e.spd   = 12'(exp_spd);
            e.stall = 1'b0;
            e.cyc   = cyc + 3;
            q.push_back(e);
        end
        last_rise = cyc;
        PWM1 = 1'b1;
        PWM2 = 1'b0;
    endtask

    task automatic exp_timeout();
        exp_t e;
        e.spd   = 12'h000;
        e.stall = 1'b1;
        e.cyc   = last_rise + 3 + TMO;
        q.push_back(e);
    endtask

    task automatic period(input int h1, input int d1, input int h2, input int d2,
                          input bit exp_v, input int exp_spd);
        rise(exp_v, exp_spd);
        hold(1'b1, 1'b0, h1);
        hold(1'b0, 1'b0, d1);
        hold(1'b0, 1'b1, h2);
        hold(1'b0, 1'b0, d2);
    endtask

    initial begin
        rst_n = 1'b0; PWM1 = 1'b0; PWM2 = 1'b0; clr_flt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_spd", int'(spd), 0);
        chk("rst_vld", int'(spd_vld), 0);
        chk("rst_stall", int'(stall), 1);
        chk("rst_shoot", int'(shoot_thru), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold(1'b0, 1'b0, 5);

        // 1500/20/508/20 periods -> 992 each, first rise only arms the measurement
        period(1500, 20, 508, 20, 1'b0, 0);
        for (int i = 0; i < 3; i++) period(1500, 20, 508, 20, 1'b1, 992);
        period(20, 20, 1988, 20, 1'b1, 992);
        period(1004, 20, 1004, 20, 1'b1, -1968);
        period(1004, 20, 1004, 20, 1'b1, 0);
        // all-low: timeout measured from the last restart, no repeat pulse
        exp_timeout();
        hold(1'b0, 1'b0, 3000);
        chk("stall_low", int'(stall), 1);
        chk("spd_low", int'(spd), 0);

        // resume: first pulse only on the 2nd rise
        period(1500, 20, 508, 20, 1'b0, 0);
        period(1500, 20, 508, 20, 1'b1, 992);
        // PWM1 stuck high
        rise(1'b1, 992);
        exp_timeout();
        hold(1'b1, 1'b0, 5000);
        chk("stall_high", int'(stall), 1);
        hold(1'b0, 1'b0, 10);

        // shoot-through
        chk("shoot_clear0", int'(shoot_thru), 0);
        hold(1'b0, 1'b1, 5);
        rise(1'b0, 0);
        exp_timeout();
        hold(1'b1, 1'b1, 3);
        hold(1'b1, 1'b0, 6);
        chk("shoot_set", int'(shoot_thru), 1);
        hold(1'b1, 1'b0, 10);
        chk("shoot_sticky", int'(shoot_thru), 1);
        hold(1'b1, 1'b1, 4);
        clr_flt = 1'b1;
        hold(1'b1, 1'b1, 1);
        clr_flt = 1'b0;
        chk("shoot_set_wins", int'(shoot_thru), 1);
        hold(1'b1, 1'b0, 5);
        chk("shoot_before_clr", int'(shoot_thru), 1);
        clr_flt = 1'b1;
        hold(1'b1, 1'b0, 1);
        clr_flt = 1'b0;
        chk("shoot_cleared", int'(shoot_thru), 0);
        hold(1'b0, 1'b0, 4200);

        // reset mid-period (PWM1 low at reset time)
        period(1500, 20, 508, 20, 1'b0, 0);
        rise(1'b1, 992);
        hold(1'b1, 1'b0, 1500);
        hold(1'b0, 1'b0, 20);
        hold(1'b0, 1'b1, 250);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_spd", int'(spd), 0);
        chk("mid_rst_vld", int'(spd_vld), 0);
        chk("mid_rst_stall", int'(stall), 1);
        chk("mid_rst_shoot", int'(shoot_thru), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        hold(1'b0, 1'b1, 258);
        hold(1'b0, 1'b0, 20);
        period(1500, 20, 508, 20, 1'b0, 0);
        period(1500, 20, 508, 20, 1'b1, 992);
        hold(1'b0, 1'b0, 10);
        chk("pending_expectations", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
